// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons. One shared adder integrates
// signed synaptic events; a periodic sweep leaks every membrane one channel per clock.
// Fired channel IDs queue in a small FIFO and also pulse a per-channel spike vector.
module lif_neuron_array #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned W          = 8,
  parameter int unsigned WW         = 4,
  parameter int unsigned REF_W      = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TICK_DIV   = 16,
  localparam int unsigned CHW       = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CHW-1:0]   in_ch,
  input  logic [WW-1:0]    in_weight,
  input  logic [W-1:0]     cfg_thresh,
  input  logic [2:0]       cfg_leak_shift,
  input  logic [REF_W-1:0] cfg_refrac,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CHW-1:0]   out_ch,
  output logic [N_CH-1:0]  spike_vec,
  output logic             ovf,
  input  logic [CHW-1:0]   vmem_sel,
  output logic [W-1:0]     vmem_out
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {StInteg, StLeak} state_e;

  state_e         state_q, state_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic [CHW-1:0] leak_idx_q, leak_idx_d;

  logic [W-1:0]     vmem_q   [N_CH];
  logic [REF_W-1:0] refr_q   [N_CH];
  logic [CHW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      cnt_q;
  logic             ovf_q;

  logic                accept, ch_ok, refr_busy, fire, push, pop, push_ok;
  logic [W-1:0]        v_cur, v_new, v_old_leak, v_leak;
  logic signed [W+1:0] sum;
  logic [N_CH-1:0]     spike_d;

  // Events are held off during reset and for the whole leak sweep.
  assign in_ready  = (state_q == StInteg) && !rst;
  assign out_valid = (cnt_q != '0);
  assign out_ch    = fifo_mem[rd_ptr_q];
  assign ovf       = ovf_q;
  assign vmem_out  = (int'(vmem_sel) < int'(N_CH)) ? vmem_q[vmem_sel] : '0;

  // Sequencer registers: FSM state, free-running tick counter, sweep index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StInteg;
      tick_q     <= '0;
      leak_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      leak_idx_q <= leak_idx_d;
    end
  end

  // Next-state: start a sweep on tick wrap, visit channels 0..N_CH-1, then resume integration.
  always_comb begin
    state_d    = state_q;
    leak_idx_d = leak_idx_q;
    tick_d     = (tick_q == TW'(TICK_DIV - 1)) ? '0 : tick_q + TW'(1);
    unique case (state_q)
      StInteg: begin
        if (tick_q == TW'(TICK_DIV - 1)) begin
          state_d    = StLeak;
          leak_idx_d = '0;
        end
      end
      StLeak: begin
        leak_idx_d = leak_idx_q + CHW'(1);
        if (leak_idx_q == CHW'(N_CH - 1)) state_d = StInteg;
      end
      default: state_d = StInteg;
    endcase
  end

  // Shared integrate/fire datapath, leak arithmetic and FIFO handshake decode.
  always_comb begin
    accept     = in_valid && in_ready;
    ch_ok      = (int'(in_ch) < int'(N_CH));
    v_cur      = ch_ok ? vmem_q[in_ch] : '0;
    refr_busy  = ch_ok && (refr_q[in_ch] != '0);
    sum        = $signed({2'b00, v_cur}) +
                 $signed({{(W + 2 - WW){in_weight[WW-1]}}, in_weight});
    // Clamp to [0, 2^W-1]: bit W+1 flags negative, bit W flags overflow.
    if (sum[W+1])  v_new = '0;
    else if (sum[W]) v_new = '1;
    else           v_new = sum[W-1:0];
    fire       = accept && ch_ok && !refr_busy && (cfg_thresh != '0) && (v_new >= cfg_thresh);
    push       = fire;
    pop        = out_valid && out_ready;
    push_ok    = push && ((cnt_q != (PW + 1)'(FIFO_DEPTH)) || pop);
    spike_d    = '0;
    if (fire) spike_d[in_ch] = 1'b1;
    v_old_leak = vmem_q[leak_idx_q];
    v_leak     = (cfg_leak_shift == 3'd0) ? v_old_leak :
                 v_old_leak - (v_old_leak >> cfg_leak_shift);
  end

  // Membranes, refractory counters, spike pulse and output FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        vmem_q[i] <= '0;
        refr_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      spike_vec <= '0;
    end else begin
      spike_vec <= spike_d;
      if (state_q == StLeak) begin
        vmem_q[leak_idx_q] <= v_leak;
        if (refr_q[leak_idx_q] != '0) refr_q[leak_idx_q] <= refr_q[leak_idx_q] - REF_W'(1);
      end
      // Refractory neurons swallow events; a fire resets even if the FIFO drops the spike.
      if (accept && ch_ok && !refr_busy) begin
        if (fire) begin
          vmem_q[in_ch] <= '0;
          refr_q[in_ch] <= cfg_refrac;
        end else begin
          vmem_q[in_ch] <= v_new;
        end
      end
      if (push_ok) begin
        fifo_mem[wr_ptr_q] <= in_ch;
        wr_ptr_q           <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_ok && !pop)      cnt_q <= cnt_q + (PW + 1)'(1);
      else if (!push_ok && pop) cnt_q <= cnt_q - (PW + 1)'(1);
      if (push && !push_ok) ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array; fired channel IDs are checked by a scoreboard monitor.
module tb_lif_neuron_array;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_ch;
  logic [3:0] in_weight;
  logic [7:0] cfg_thresh;
  logic [2:0] cfg_leak_shift;
  logic [2:0] cfg_refrac;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_ch;
  logic [3:0] spike_vec;
  logic       ovf;
  logic [1:0] vmem_sel;
  logic [7:0] vmem_out;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  lif_neuron_array dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .in_weight(in_weight), .cfg_thresh(cfg_thresh), .cfg_leak_shift(cfg_leak_shift),
    .cfg_refrac(cfg_refrac), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .spike_vec(spike_vec), .ovf(ovf), .vmem_sel(vmem_sel), .vmem_out(vmem_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: settles after the negedge drive, then checks each popped ID against the scoreboard.
  always @(negedge clk) begin
    #2;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop actual=%0d required=none", out_ch);
      end else begin
        check("out_ch", {30'd0, out_ch}, {30'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic check_v(input string name, input logic [1:0] ch, input int req);
    vmem_sel = ch;
    #1;
    check(name, {24'd0, vmem_out}, req);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [1:0] ch, input logic [3:0] w);
    int n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=%0d required=1", in_ready);
    end else begin
      in_valid  = 1'b1;
      in_ch     = ch;
      in_weight = w;
      @(negedge clk);
      in_valid  = 1'b0;
    end
  endtask

  // Wait for the next sweep; count negedges with in_ready low.
  task automatic wait_low(output int lows);
    int n = 0;
    while (in_ready === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    lows = 0;
    while (in_ready !== 1'b1 && lows < 100) begin
      lows++;
      @(negedge clk);
    end
  endtask

  task automatic count_high(output int highs);
    highs = 0;
    while (in_ready === 1'b1 && highs < 100) begin
      highs++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lows, highs;
    rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_weight = '0; out_ready = 1'b1;
    cfg_thresh = 8'd10; cfg_leak_shift = 3'd0; cfg_refrac = 3'd0; vmem_sel = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 0);
    rst = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_spike_vec", {28'd0, spike_vec}, 0);
    check("rst_ovf", {31'd0, ovf}, 0);
    check("rst_in_ready_after", {31'd0, in_ready}, 1);
    check_v("rst_vmem1", 2'd1, 0);
    @(negedge clk);

    // Basic integrate and fire on channel 1.
    send(2'd1, 4'sd7);
    check_v("int_vmem1", 2'd1, 7);
    check("int_no_spike", {28'd0, spike_vec}, 0);
    exp_q.push_back(2'd1);
    send(2'd1, 4'sd7);
    check("fire_spike_vec", {28'd0, spike_vec}, 4'b0010);
    check("fire_out_valid", {31'd0, out_valid}, 1);
    check_v("fire_vmem1", 2'd1, 0);
    @(negedge clk);
    check("spike_one_cycle", {28'd0, spike_vec}, 0);

    // Saturation with firing disabled.
    cfg_thresh = 8'd0;
    for (int i = 0; i < 35; i++) send(2'd0, 4'sd7);
    send(2'd0, 4'sd5);
    check_v("sat_pre", 2'd0, 250);
    send(2'd0, 4'sd7);
    check_v("sat_hi", 2'd0, 255);
    send(2'd0, 4'sd7);
    check_v("sat_hi_hold", 2'd0, 255);
    send(2'd3, 4'sd3);
    send(2'd3, -4'sd8);
    check_v("sat_lo", 2'd3, 0);
    check("thresh0_no_fire", {31'd0, out_valid}, 0);

    // Bring channel 0 to 128, then leak by halves.
    for (int i = 0; i < 15; i++) send(2'd0, -4'sd8);
    send(2'd0, -4'sd7);
    check_v("leak_pre", 2'd0, 128);
    cfg_leak_shift = 3'd1;
    wait_low(lows);
    check("leak_low1", lows, 4);
    check_v("leak_64", 2'd0, 64);
    count_high(highs);
    check("leak_period_high", highs, 12);
    wait_low(lows);
    check("leak_low2", lows, 4);
    check_v("leak_32", 2'd0, 32);
    cfg_leak_shift = 3'd0;

    // Refractory: ignore events for two sweeps after firing.
    cfg_thresh = 8'd10;
    cfg_refrac = 3'd2;
    wait_low(lows);
    send(2'd2, 4'sd7);
    exp_q.push_back(2'd2);
    send(2'd2, 4'sd7);
    check("refr_fire", {28'd0, spike_vec}, 4'b0100);
    send(2'd2, 4'sd7);
    check_v("refr_ignored0", 2'd2, 0);
    wait_low(lows);
    send(2'd2, 4'sd7);
    check_v("refr_ignored1", 2'd2, 0);
    wait_low(lows);
    cfg_refrac = 3'd0;
    send(2'd2, 4'sd7);
    check_v("refr_over", 2'd2, 7);
    exp_q.push_back(2'd2);
    send(2'd2, 4'sd7);
    check("refr_refire", {28'd0, spike_vec}, 4'b0100);
    @(negedge clk);

    // FIFO overflow: five fires into a four-entry FIFO with no pops.
    out_ready = 1'b0;
    cfg_thresh = 8'd5;
    send(2'd3, 4'sd7); exp_q.push_back(2'd3);
    send(2'd1, 4'sd7); exp_q.push_back(2'd1);
    send(2'd0, 4'sd7); exp_q.push_back(2'd0);
    send(2'd2, 4'sd7); exp_q.push_back(2'd2);
    check("ovf_before", {31'd0, ovf}, 0);
    send(2'd0, 4'sd7);
    check("ovf_after", {31'd0, ovf}, 1);
    check_v("ovf_vmem_reset", 2'd0, 0);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("fifo_drained", {31'd0, out_valid}, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    // Reset mid-sweep with a queued spike and a charged membrane.
    out_ready = 1'b0;
    send(2'd2, 4'sd3);
    send(2'd1, 4'sd7);
    check("pre_rst_queued", {31'd0, out_valid}, 1);
    begin
      int n = 0;
      while (in_ready === 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", {31'd0, in_ready}, 0);
    check("mid_rst_out_valid", {31'd0, out_valid}, 0);
    check("mid_rst_ovf", {31'd0, ovf}, 0);
    check_v("mid_rst_vmem2", 2'd2, 0);
    out_ready = 1'b1;
    rst = 1'b0;
    #1;
    count_high(highs);
    check("post_rst_first_sweep", highs, 16);
    @(negedge clk);
    check("final_scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
